// File: rtl/lt_crc5_pkg.sv
// Shared CRC5 definitions for the link-layer TX generator and RX checker.
// CRC5: poly x^5+x^2+1, init all-ones, MSB first, no reflection, no final XOR.
package lt_crc5_pkg;

    localparam int CRC_W = 5;
    localparam logic [CRC_W-1:0] CRC5_POLY = 5'h05;
    localparam logic [CRC_W-1:0] CRC5_INIT = 5'h1F;

    // Widest payload crc5_calc() can take; callers zero-extend into this.
    localparam int CRC5_MAX_BITS = 64;

    // Serial CRC5 over the low nbits of data, highest of those bits first.
    function automatic logic [CRC_W-1:0] crc5_calc(
        input logic [CRC5_MAX_BITS-1:0] data,
        input int                       nbits
    );
        logic [CRC_W-1:0] crc;
        logic             fb;
        crc = CRC5_INIT;
        for (int i = CRC5_MAX_BITS - 1; i >= 0; i--) begin
            if (i < nbits) begin
                // NOTE: blocking assignments are right here: each loop step builds
                // on the previous one within a single combinational evaluation.
                fb  = crc[CRC_W-1] ^ data[i];
                crc = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC5_POLY : '0);
            end
        end
        return crc;
    endfunction

endpackage

// File: rtl/rx_lt_crc5_calc.sv
// Combinational CRC5 of one payload word (DATA_WIDTH up to CRC5_MAX_BITS).
module rx_lt_crc5_calc
    import lt_crc5_pkg::*;
#(
    parameter int DATA_WIDTH = 11
)(
    input  logic [DATA_WIDTH-1:0] i_payload,
    output logic [CRC_W-1:0]      o_crc
);

    assign o_crc = crc5_calc(CRC5_MAX_BITS'(i_payload), DATA_WIDTH);

endmodule

// File: rtl/rx_lt_crc5_check.sv
// RX link-layer CRC5 checker: recomputes CRC5 on each incoming word, forwards
// payload + CRC_ERR flag through a 2-entry registered buffer, and keeps a
// saturating bad-word count plus a sticky LINK_ERR alarm for consecutive errors.
module rx_lt_crc5_check
    import lt_crc5_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter bit DROP_BAD   = 1'b0,
    parameter int ERR_LIMIT  = 3,
    parameter int CNT_WIDTH  = 8
)(
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [DATA_WIDTH+CRC_W-1:0] DATA_UP,
    input  logic                        VALID_UP,
    output logic                        READY_UP,
    output logic [DATA_WIDTH-1:0]       DATA_DOWN,
    output logic                        CRC_ERR_DOWN,
    output logic                        VALID_DOWN,
    input  logic                        READY_DOWN,
    input  logic                        CLR_ERR,
    output logic [CNT_WIDTH-1:0]        ERR_CNT,
    output logic                        LINK_ERR
);

    localparam int                    CONSEC_W   = $clog2(ERR_LIMIT + 1);
    localparam logic [CONSEC_W-1:0]   CONSEC_MAX = CONSEC_W'(ERR_LIMIT);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

    typedef struct packed {
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [DATA_WIDTH-1:0] w_payload;
    logic [CRC_W-1:0]      w_rx_crc;
    logic [CRC_W-1:0]      w_calc_crc;
    logic                  w_bad;
    logic                  w_accept;
    logic                  w_write;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;

    // Pointers carry a wrap bit above the 1-bit index to tell full from empty.
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    entry_t                r_mem [2];

    logic [CNT_WIDTH-1:0]  r_err_cnt;
    logic [CONSEC_W-1:0]   r_consec;
    logic                  r_link_err;

    assign w_payload = DATA_UP[DATA_WIDTH+CRC_W-1:CRC_W];
    assign w_rx_crc  = DATA_UP[CRC_W-1:0];

    rx_lt_crc5_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_calc (
        .i_payload  (w_payload),
        .o_crc      (w_calc_crc)
    );

    assign w_bad   = (w_calc_crc != w_rx_crc);
    assign w_full  = (r_wr_ptr[0] == r_rd_ptr[0]) && (r_wr_ptr[1] != r_rd_ptr[1]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Handshake flags come only from pointer registers: no VALID_UP->VALID_DOWN path.
    assign READY_UP   = !w_full;
    assign VALID_DOWN = !w_empty;

    assign w_accept = VALID_UP && !w_full;
    assign w_write  = w_accept && !(DROP_BAD && w_bad);
    assign w_pop    = !w_empty && READY_DOWN;

    assign DATA_DOWN    = r_mem[r_rd_ptr[0]].data;
    assign CRC_ERR_DOWN = r_mem[r_rd_ptr[0]].err;
    assign ERR_CNT      = r_err_cnt;
    assign LINK_ERR     = r_link_err;

    // Buffer storage: written on an accepted (and not dropped) word.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            // NOTE: the two entries are reset because DATA_DOWN/CRC_ERR_DOWN read
            // straight from storage and must be 0 out of reset.
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_write) begin
            r_mem[r_wr_ptr[0]] <= '{err: w_bad, data: w_payload};
        end
    end

    // Buffer pointers: write on accept, read on downstream pop.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
        end
    end

    // Error statistics; CLR_ERR wins over any same-cycle update.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_err_cnt  <= '0;
            r_consec   <= '0;
            r_link_err <= 1'b0;
        end else if (CLR_ERR) begin
            r_err_cnt  <= '0;
            r_consec   <= '0;
            r_link_err <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_bad) begin
                    if (r_err_cnt != CNT_MAX) begin
                        r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
                    end
                    if (r_consec != CONSEC_MAX) begin
                        r_consec <= r_consec + CONSEC_W'(1);
                    end
                end else begin
                    r_consec <= '0;
                end
            end
            // Alarm follows the registered run length, so it rises one cycle
            // after the run reaches ERR_LIMIT, then stays until cleared.
            if (r_consec == CONSEC_MAX) begin
                r_link_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_lt_crc5_check.sv
// Bench for rx_lt_crc5_check: two instances (DROP_BAD=0 and DROP_BAD=1), a
// polynomial-division CRC reference, expected-word queues popped by a monitor.
module tb_rx_lt_crc5_check;

    localparam int DW    = 11;
    localparam int LIMIT = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;

    logic [DW+4:0] data_up    [2];
    logic          valid_up   [2];
    logic          ready_up   [2];
    logic [DW-1:0] data_down  [2];
    logic          crc_err    [2];
    logic          valid_down [2];
    logic          ready_down [2] = '{1'b1, 1'b1};
    logic          clr_err    [2];
    logic [7:0]    err_cnt    [2];
    logic          link_err   [2];

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_pass   = 0;

    int m_cnt    [2];
    int m_consec [2];
    bit m_link   [2];
    int popped   [2];

    bit ready_rand  [2];
    bit ready_force [2] = '{1'b1, 1'b1};

    bit            hold_v [2];
    logic [DW-1:0] hold_d [2];
    logic          hold_e [2];

    always #5 clk = ~clk;

    rx_lt_crc5_check #(
        .DATA_WIDTH (DW), .DROP_BAD (1'b0), .ERR_LIMIT (LIMIT), .CNT_WIDTH (8)
    ) dut0 (
        .CLK (clk), .RESET (rst_n),
        .DATA_UP (data_up[0]), .VALID_UP (valid_up[0]), .READY_UP (ready_up[0]),
        .DATA_DOWN (data_down[0]), .CRC_ERR_DOWN (crc_err[0]),
        .VALID_DOWN (valid_down[0]), .READY_DOWN (ready_down[0]),
        .CLR_ERR (clr_err[0]), .ERR_CNT (err_cnt[0]), .LINK_ERR (link_err[0])
    );

    rx_lt_crc5_check #(
        .DATA_WIDTH (DW), .DROP_BAD (1'b1), .ERR_LIMIT (LIMIT), .CNT_WIDTH (8)
    ) dut1 (
        .CLK (clk), .RESET (rst_n),
        .DATA_UP (data_up[1]), .VALID_UP (valid_up[1]), .READY_UP (ready_up[1]),
        .DATA_DOWN (data_down[1]), .CRC_ERR_DOWN (crc_err[1]),
        .VALID_DOWN (valid_down[1]), .READY_DOWN (ready_down[1]),
        .CLR_ERR (clr_err[1]), .ERR_CNT (err_cnt[1]), .LINK_ERR (link_err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference CRC: remainder of (payload xor init*x^(DW-5)) * x^5 modulo x^5+x^2+1.
    function automatic logic [4:0] ref_crc(input logic [DW-1:0] p);
        logic [DW+4:0] r;
        r = {p ^ {5'h1F, {(DW-5){1'b0}}}, 5'b0};
        for (int i = DW + 4; i >= 5; i--) begin
            if (r[i]) r[i -: 6] = r[i -: 6] ^ 6'b100101;
        end
        return r[4:0];
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void model_clear();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_consec[i] = 0; m_link[i] = 1'b0; popped[i] = 0;
        end
    endfunction

    function automatic void model_accept(input int i, input logic [DW-1:0] p,
                                         input logic [4:0] c, input bit clr);
        bit   bad;
        exp_t e;
        bad = (c != ref_crc(p));
        if (clr) begin
            m_cnt[i] = 0; m_consec[i] = 0; m_link[i] = 1'b0;
        end else if (bad) begin
            if (m_cnt[i] < 255) m_cnt[i]++;
            if (m_consec[i] < LIMIT) m_consec[i]++;
            if (m_consec[i] == LIMIT) m_link[i] = 1'b1;
        end else begin
            m_consec[i] = 0;
        end
        // Instance 1 discards words that fail the CRC.
        if (!(i == 1 && bad)) begin
            e.data = p;
            e.err  = bad;
            if (i == 0) q0.push_back(e); else q1.push_back(e);
        end
    endfunction

    // READY_DOWN driver: forced level or random, updated just after each rising edge.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            ready_down[i] = ready_rand[i] ? 1'($urandom_range(0, 1)) : ready_force[i];
        end
    end

    // Monitor: compares each popped word against the expected queue and checks
    // that a stalled output holds still.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                hold_v[i] = 1'b0;
            end else begin
                if (hold_v[i]) begin
                    check("hold_stable", {valid_down[i], data_down[i], crc_err[i]},
                          {1'b1, hold_d[i], hold_e[i]});
                end
                if (valid_down[i] && ready_down[i]) begin
                    exp_t e;
                    if (qsize(i) == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_pop inst%0d: got data 0x%0h, expected no word",
                                 i, data_down[i]);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        check("down_data", data_down[i], e.data);
                        check("down_err", crc_err[i], e.err);
                    end
                    popped[i]++;
                end
                hold_v[i] = valid_down[i] && !ready_down[i];
                hold_d[i] = data_down[i];
                hold_e[i] = crc_err[i];
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one word; the model is updated at the edge where it is accepted.
    task automatic send(input int i, input logic [DW-1:0] p, input logic [4:0] c,
                        input bit clr, input int gap);
        int waited;
        idle(gap);
        data_up[i]  = {p, c};
        valid_up[i] = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (ready_up[i]) break;
            waited++;
            if (waited > 300) begin
                n_checks++;
                $display("FAIL send_timeout inst%0d: READY_UP stayed 0 for %0d cycles", i, waited);
                valid_up[i] = 1'b0;
                return;
            end
        end
        clr_err[i] = clr;
        model_accept(i, p, c, clr);
        @(posedge clk);
        #1;
        valid_up[i] = 1'b0;
        clr_err[i]  = 1'b0;
    endtask

    task automatic send_rand(input int i, input bit bad, input bit clr, input int gap);
        logic [DW-1:0] p;
        logic [4:0]    c;
        p = DW'($urandom);
        c = ref_crc(p) ^ (bad ? 5'($urandom_range(1, 31)) : 5'd0);
        send(i, p, c, clr, gap);
    endtask

    task automatic drain(input int i, input string tag);
        int n;
        ready_rand[i]  = 1'b0;
        ready_force[i] = 1'b1;
        n = 0;
        while (qsize(i) != 0 && n < 60) begin
            idle(1);
            n++;
        end
        idle(2);
        check({tag, "_queue_empty"}, qsize(i), 0);
        check({tag, "_err_cnt"}, err_cnt[i], m_cnt[i]);
        check({tag, "_link_err"}, link_err[i], m_link[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            data_up[i] = '0; valid_up[i] = 1'b0; clr_err[i] = 1'b0;
        end
        model_clear();
        rst_n = 1'b0;
        idle(3);
        for (int i = 0; i < 2; i++) begin
            check("rst_ready_up", ready_up[i], 1);
            check("rst_valid_down", valid_down[i], 0);
            check("rst_data_down", data_down[i], 0);
            check("rst_crc_err", crc_err[i], 0);
            check("rst_err_cnt", err_cnt[i], 0);
            check("rst_link_err", link_err[i], 0);
        end
        rst_n = 1'b1;
        idle(2);

        // 1: good word 11'h000 / 5'h17 appears one cycle after accept.
        send(0, 11'h000, 5'h17, 1'b0, 0);
        check("t1_valid_down", valid_down[0], 1);
        check("t1_data_down", data_down[0], 0);
        check("t1_crc_err", crc_err[0], 0);
        check("t1_err_cnt", err_cnt[0], 0);
        idle(2);

        // 2: same payload with wrong CRC is forwarded and flagged.
        send(0, 11'h000, 5'h16, 1'b0, 0);
        check("t2_crc_err", crc_err[0], 1);
        check("t2_err_cnt", err_cnt[0], 1);
        idle(2);
        check("t2_link_err", link_err[0], 0);

        // 3: stalled downstream fills both entries, third word waits.
        ready_force[0] = 1'b0;
        idle(2);
        send_rand(0, 1'b0, 1'b0, 0);
        send_rand(0, 1'b0, 1'b0, 0);
        check("t3_full_ready_up", ready_up[0], 0);
        idle(3);
        check("t3_still_full", ready_up[0], 0);
        ready_force[0] = 1'b1;
        send_rand(0, 1'b0, 1'b0, 0);
        idle(4);
        check("t3_drained", valid_down[0], 0);

        // 4: bad,bad,good,bad,bad,bad back to back.
        clr_err[0] = 1'b1;
        model_accept(0, 11'h000, 5'h17, 1'b1);
        void'(q0.pop_back());
        idle(1);
        clr_err[0] = 1'b0;
        send_rand(0, 1'b1, 1'b0, 0);
        send_rand(0, 1'b1, 1'b0, 0);
        send_rand(0, 1'b0, 1'b0, 0);
        send_rand(0, 1'b1, 1'b0, 0);
        send_rand(0, 1'b1, 1'b0, 0);
        send_rand(0, 1'b1, 1'b0, 0);
        check("t4_link_not_yet", link_err[0], 0);
        idle(1);
        check("t4_link_rise", link_err[0], 1);
        check("t4_err_cnt", err_cnt[0], 5);
        idle(3);

        // 5: dropping instance forwards only the good words.
        send_rand(1, 1'b0, 1'b0, 0);
        send_rand(1, 1'b1, 1'b0, 0);
        send_rand(1, 1'b0, 1'b0, 0);
        idle(3);
        check("t5_words_out", popped[1], 2);
        check("t5_err_cnt", err_cnt[1], 1);

        // 6: CLR_ERR beats a coincident bad word; reset flushes the buffer.
        send_rand(0, 1'b1, 1'b1, 0);
        idle(2);
        check("t6_clr_err_cnt", err_cnt[0], 0);
        check("t6_clr_link_err", link_err[0], 0);
        ready_force[0] = 1'b0;
        idle(2);
        send_rand(0, 1'b0, 1'b0, 0);
        send_rand(0, 1'b1, 1'b0, 0);
        check("t6_buffered", valid_down[0], 1);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("t6_rst_valid_down", valid_down[0], 0);
        check("t6_rst_ready_up", ready_up[0], 1);
        check("t6_rst_data_down", data_down[0], 0);
        check("t6_rst_err_cnt", err_cnt[0], 0);
        ready_force[0] = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Random traffic with upstream gaps and downstream stalls on both instances.
        for (int i = 0; i < 2; i++) begin
            ready_rand[i] = 1'b1;
            for (int k = 0; k < 80; k++) begin
                send_rand(i, ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
                          $urandom_range(0, 2));
            end
            drain(i, (i == 0) ? "rand_keep" : "rand_drop");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
